cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl_pkg.sv | 20 ++
 rtl/cache_burst_cnt.sv | 27 ++
 rtl/cache_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cache_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache controller.
package cache_ctrl_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle,
    StCompare,
    StWriteback,
    StAllocate
  } state_e;

  localparam int unsigned WORDS_PER_LINE_DEF = 4;
  localparam int unsigned OFF_W_DEF          = $clog2(WORDS_PER_LINE_DEF);

  // Width of the word-in-line offset for a given line size.
  function automatic int unsigned off_w(input int unsigned words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/cache_burst_cnt.sv
// Word-in-line burst counter with last-word detect; wraps modulo the line size.
module cache_burst_cnt #(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned OFF_W          = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [OFF_W-1:0] cnt,
  output logic             last
);

  logic [OFF_W-1:0] cnt_q;

  // Count one per accepted word; natural wrap returns to 0 after the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == OFF_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/cache_ctrl.sv
// Write-back cache controller FSM: compare, dirty writeback burst, allocate burst.
// Optional hit/miss statistics counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int unsigned ADDR_W         = 15
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cpu_req,
  input  logic                                cpu_we,
  input  logic [ADDR_W-1:0]                   cpu_addr,
  output logic                                cpu_ready,
  input  logic                                dp_hit,
  input  logic                                dp_dirty,
  input  logic [ADDR_W-off_w(WORDS_PER_LINE)-1:0] dp_victim_line,
  output logic [ADDR_W-1:0]                   dp_addr,
  output logic                                dp_data_we,
  output logic                                dp_fill_we,
  output logic                                dp_tag_we,
  output logic                                dp_dirty_set,
  output logic                                dp_dirty_clr,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [ADDR_W-1:0]                   mem_addr,
  input  logic                                mem_ack
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0]                         hit_cnt,
  output logic [15:0]                         miss_cnt
`endif
);

  localparam int unsigned OFF_W = off_w(WORDS_PER_LINE);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              latch;
  logic              ready_d, ready_q;
  logic              data_we_q, dirty_set_q;
  logic              burst_inc, burst_last;
  logic [OFF_W-1:0]  word_cnt;

  cache_burst_cnt #(
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .OFF_W         (OFF_W)
  ) u_burst_cnt (
    .clk (clk),
    .rst (rst),
    .inc (burst_inc),
    .cnt (word_cnt),
    .last(burst_last)
  );

  // Next-state decode and burst-side strobes.
  always_comb begin
    state_d      = state_q;
    latch        = 1'b0;
    ready_d      = 1'b0;
    burst_inc    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    dp_fill_we   = 1'b0;
    dp_tag_we    = 1'b0;
    dp_dirty_clr = 1'b0;
    case (state_q)
      StIdle: begin
        // The request is still held during the ready pulse; do not re-accept it.
        if (cpu_req && !ready_q) begin
          latch   = 1'b1;
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (dp_hit) begin
          ready_d = 1'b1;
          state_d = StIdle;
        end else if (dp_dirty) begin
          state_d = StWriteback;
        end else begin
          state_d = StAllocate;
        end
      end
      StWriteback: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {dp_victim_line, word_cnt};
        if (mem_ack) begin
          burst_inc = 1'b1;
          if (burst_last) state_d = StAllocate;
        end
      end
      StAllocate: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[ADDR_W-1:OFF_W], word_cnt};
        if (mem_ack) begin
          burst_inc  = 1'b1;
          dp_fill_we = 1'b1;
          if (burst_last) begin
            dp_tag_we    = 1'b1;
            dp_dirty_clr = 1'b1;
            state_d      = StCompare;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, latched request and registered completion strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      we_q        <= 1'b0;
      ready_q     <= 1'b0;
      data_we_q   <= 1'b0;
      dirty_set_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      data_we_q   <= ready_d & we_q;
      dirty_set_q <= ready_d & we_q;
      if (latch) begin
        addr_q <= cpu_addr;
        we_q   <= cpu_we;
      end
    end
  end

  assign cpu_ready    = ready_q;
  assign dp_data_we   = data_we_q;
  assign dp_dirty_set = dirty_set_q;
  assign dp_addr      = (state_q == StIdle) ? cpu_addr : addr_q;

`ifdef CACHE_CTRL_STATS_EN
  logic refill_q;

  // Saturating hit/miss counters; the compare that follows a refill is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      refill_q <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      refill_q <= (state_q == StAllocate);
      if (state_q == StCompare && !refill_q) begin
        if (dp_hit) begin
          if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
        end else begin
          if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: stimulus pushes expected memory beats, tag
// writes and ready pulses; a negedge monitor pops and compares them.
module tb_cache_ctrl;

  localparam int K_MEM = 0;
  localparam int K_TAG = 1;
  localparam int K_RDY = 2;

  typedef struct {
    int          kind;
    bit          we;
    logic [14:0] addr;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic        cpu_ready;
  logic        tb_hit = 1'b0;
  logic        filled = 1'b0;
  logic        dp_hit;
  logic        dp_dirty = 1'b0;
  logic [12:0] dp_victim_line = '0;
  logic [14:0] dp_addr;
  logic        dp_data_we, dp_fill_we, dp_tag_we, dp_dirty_set, dp_dirty_clr;
  logic        mem_req, mem_we;
  logic [14:0] mem_addr;
  logic        ack_en = 1'b1;
  logic        mem_ack;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  exp_t exp_q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mem_cycles = 0;
  int   beats = 0;
  int   tags = 0;

  assign dp_hit  = tb_hit | filled;
  assign mem_ack = ack_en;

  cache_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_ready     (cpu_ready),
    .dp_hit        (dp_hit),
    .dp_dirty      (dp_dirty),
    .dp_victim_line(dp_victim_line),
    .dp_addr       (dp_addr),
    .dp_data_we    (dp_data_we),
    .dp_fill_we    (dp_fill_we),
    .dp_tag_we     (dp_tag_we),
    .dp_dirty_set  (dp_dirty_set),
    .dp_dirty_clr  (dp_dirty_clr),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tiny datapath model: a line becomes a hit once its tag is written.
  always @(posedge clk) begin
    if (rst || cpu_ready) filled <= 1'b0;
    else if (dp_tag_we) filled <= 1'b1;
  end

  // Monitor: pop and compare on every memory beat, tag write and ready pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) mem_cycles++;
      if (mem_req && mem_ack) begin
        beats++;
        checks++;
        if (exp_q.size() == 0 || exp_q[0].kind != K_MEM) begin
          errors++;
          $display("FAIL mem_beat: unexpected beat we=%0b addr=%h", mem_we, mem_addr);
        end else begin
          me = exp_q.pop_front();
          if (mem_we !== me.we || mem_addr !== me.addr || dp_fill_we !== ~me.we) begin
            errors++;
            $display("FAIL mem_beat: got we=%0b addr=%h fill=%0b, want we=%0b addr=%h fill=%0b",
                     mem_we, mem_addr, dp_fill_we, me.we, me.addr, ~me.we);
          end
        end
      end
      if (dp_tag_we) begin
        tags++;
        checks++;
        if (exp_q.size() == 0 || exp_q[0].kind != K_TAG) begin
          errors++;
          $display("FAIL tag_we: unexpected tag write at cycle %0d", cyc);
        end else begin
          me = exp_q.pop_front();
          if (dp_dirty_clr !== 1'b1) begin
            errors++;
            $display("FAIL tag_we: dirty_clr got %0b want 1", dp_dirty_clr);
          end
        end
      end
      if (cpu_ready) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].kind != K_RDY) begin
          errors++;
          $display("FAIL cpu_ready: unexpected ready at cycle %0d", cyc);
        end else begin
          me = exp_q.pop_front();
          if (cyc != me.cyc || dp_data_we !== me.we || dp_dirty_set !== me.we) begin
            errors++;
            $display("FAIL cpu_ready: got cyc=%0d data_we=%0b dirty_set=%0b, want cyc=%0d both=%0b",
                     cyc, dp_data_we, dp_dirty_set, me.cyc, me.we);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input bit we, input logic [14:0] addr, input int c);
    exp_t e;
    e.kind = kind;
    e.we   = we;
    e.addr = addr;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // One CPU access; lat and burst base addresses are hand-computed by the caller.
  task automatic access(input bit we, input logic [14:0] addr, input bit hit, input bit dirty,
                        input logic [12:0] victim, input int lat,
                        input logic [14:0] wb_base, input logic [14:0] rd_base);
    int t0;
    int mc0;
    bit seen;
    step();
    t0  = cyc;
    mc0 = mem_cycles;
    if (!hit) begin
      if (dirty) for (int i = 0; i < 4; i++) push(K_MEM, 1'b1, wb_base + 15'(i), 0);
      for (int i = 0; i < 4; i++) push(K_MEM, 1'b0, rd_base + 15'(i), 0);
      push(K_TAG, 1'b0, '0, 0);
    end
    push(K_RDY, we, addr, t0 + lat);
    cpu_req        = 1'b1;
    cpu_we         = we;
    cpu_addr       = addr;
    tb_hit         = hit;
    dp_dirty       = dirty;
    dp_victim_line = victim;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = cpu_ready;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: addr=%h no cpu_ready within 40 cycles", addr);
    end
    step();
    cpu_req  = 1'b0;
    tb_hit   = 1'b0;
    dp_dirty = 1'b0;
    if (hit) begin
      checks++;
      if (mem_cycles != mc0) begin
        errors++;
        $display("FAIL hit_no_mem: mem_req high %0d cycles, want 0", mem_cycles - mc0);
      end
    end
  endtask

  initial begin
    int b0;
    int t0;
    // Reset: everything quiet, dp_addr follows cpu_addr in idle.
    cpu_addr = 15'h5555;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({cpu_ready, mem_req, mem_we, dp_data_we, dp_fill_we, dp_tag_we, dp_dirty_set,
         dp_dirty_clr} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {cpu_ready, mem_req, mem_we, dp_data_we, dp_fill_we, dp_tag_we,
                dp_dirty_set, dp_dirty_clr});
    end
    checks++;
    if (dp_addr !== 15'h5555) begin
      errors++;
      $display("FAIL idle_dp_addr: got %h want 5555", dp_addr);
    end
    step();
    rst = 1'b0;

    access(1'b0, 15'h0001, 1'b1, 1'b0, 13'h0000, 2, 15'h0000, 15'h0000);   // read hit
    access(1'b0, 15'h0001, 1'b0, 1'b0, 13'h0000, 7, 15'h0000, 15'h0000);   // read miss clean
    access(1'b0, 15'h0800, 1'b0, 1'b1, 13'h0010, 11, 15'h0040, 15'h0800);  // dirty miss
    access(1'b1, 15'h1234, 1'b1, 1'b0, 13'h0000, 2, 15'h0000, 15'h0000);   // write hit
    access(1'b1, 15'h0123, 1'b0, 1'b0, 13'h0000, 7, 15'h0000, 15'h0120);   // write miss clean

    // Reset in the middle of an allocate burst.
    step();
    b0 = beats;
    t0 = tags;
    push(K_MEM, 1'b0, 15'h0444, 0);
    push(K_MEM, 1'b0, 15'h0445, 0);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 15'h0444;
    for (int n = 0; n < 20 && beats < b0 + 2; n++) step();
    rst     = 1'b1;
    cpu_req = 1'b0;
    ack_en  = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || cpu_ready !== 1'b0 || dp_tag_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_alloc: mem_req=%0b ready=%0b tag_we=%0b want all 0",
               mem_req, cpu_ready, dp_tag_we);
    end
    checks++;
    if (beats != b0 + 2 || tags != t0) begin
      errors++;
      $display("FAIL reset_mid_beats: beats=%0d tags=%0d want beats=%0d tags=%0d",
               beats - b0, tags - t0, 2, 0);
    end
    step();
    rst    = 1'b0;
    ack_en = 1'b1;

    // One miss plus three hits after a fresh reset.
    access(1'b0, 15'h0001, 1'b1, 1'b0, 13'h0000, 2, 15'h0000, 15'h0000);
    access(1'b0, 15'h0005, 1'b0, 1'b0, 13'h0000, 7, 15'h0000, 15'h0004);
    access(1'b1, 15'h1234, 1'b1, 1'b0, 13'h0000, 2, 15'h0000, 15'h0000);
    access(1'b0, 15'h0010, 1'b1, 1'b0, 13'h0000, 2, 15'h0000, 15'h0000);

    repeat (3) step();
    @(negedge clk);
`ifdef CACHE_CTRL_STATS_EN
    checks++;
    if (hit_cnt !== 16'd3 || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stats: hit_cnt=%0d miss_cnt=%0d want 3 and 1", hit_cnt, miss_cnt);
    end
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected events left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
